// File: rtl/div_pkg.sv
// Shared definitions for the repeated-subtraction divider: FSM state encoding and default width.
package div_pkg;

  localparam int DIV_W_DEFAULT = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_CALC   = 3'd3,
    S_DONE   = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_controller.sv
// FSM controller for div_repsub: sequences operand loads, subtract loop and completion.
module div_controller
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic eqz,
  input  logic lt,
  output logic lda,
  output logic ldb,
  output logic clrq,
  output logic ldr_sub,
  output logic incq,
  output logic set_dz,
  output logic busy,
  output logic done
);

  div_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    lda     = 1'b0;
    ldb     = 1'b0;
    clrq    = 1'b0;
    ldr_sub = 1'b0;
    incq    = 1'b0;
    set_dz  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        busy    = 1'b1;
        lda     = 1'b1;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        busy    = 1'b1;
        ldb     = 1'b1;
        clrq    = 1'b1;
        state_d = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        // Zero divisor takes priority: a zero D would otherwise loop forever since R>=0 always.
        if (eqz) begin
          set_dz  = 1'b1;
          state_d = S_DONE;
        end else if (!lt) begin
          ldr_sub = 1'b1;
          incq    = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_d = S_LOAD_A;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: rtl/div_repsub.sv
// Unsigned divider by repeated subtraction: R/D/Q datapath around div_controller.
// Optional feature macro: DIV_CYCLE_COUNT_EN adds the calc_cycles output and counter.
module div_repsub
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
`ifdef DIV_CYCLE_COUNT_EN
  output logic [WIDTH-1:0] calc_cycles,
`endif
  output logic             div_by_zero
);

  logic [WIDTH-1:0] r_q, r_d, d_q, d_d, q_q, q_d;
  logic             dz_q, dz_d;
  logic             lda, ldb, clrq, ldr_sub, incq, set_dz;
  logic             eqz, lt;

  assign eqz = (d_q == '0);
  assign lt  = (r_q < d_q);

  div_controller u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .eqz     (eqz),
    .lt      (lt),
    .lda     (lda),
    .ldb     (ldb),
    .clrq    (clrq),
    .ldr_sub (ldr_sub),
    .incq    (incq),
    .set_dz  (set_dz),
    .busy    (busy),
    .done    (done)
  );

  always_comb begin
    r_d  = r_q;
    d_d  = d_q;
    q_d  = q_q;
    dz_d = dz_q;
    if (lda)          r_d = data_in;
    else if (ldr_sub) r_d = r_q - d_q;
    if (ldb) d_d = data_in;
    if (clrq)        q_d = '0;
    else if (set_dz) q_d = '1;
    else if (incq)   q_d = q_q + 1'b1;
    if (lda)         dz_d = 1'b0;
    else if (set_dz) dz_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q  <= '0;
      d_q  <= '0;
      q_q  <= '0;
      dz_q <= 1'b0;
    end else begin
      r_q  <= r_d;
      d_q  <= d_d;
      q_q  <= q_d;
      dz_q <= dz_d;
    end
  end

  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dz_q;

`ifdef DIV_CYCLE_COUNT_EN
  logic [WIDTH-1:0] cyc_q, cyc_d;
  logic             in_calc;

  // CALC is the only busy state that is not a load state; the exiting edge counts too.
  assign in_calc = busy & ~lda & ~ldb;

  always_comb begin
    cyc_d = cyc_q;
    if (ldb)          cyc_d = '0;
    else if (in_calc) cyc_d = cyc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  assign calc_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_div_repsub.sv
// Scoreboard bench for div_repsub: directed divisions, div-by-zero, reset abort, back-to-back ops.
module tb_div_repsub;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           busy_cycles;
    logic [W-1:0] cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;
`ifdef DIV_CYCLE_COUNT_EN
  logic [W-1:0] calc_cycles;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  div_repsub #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .data_in     (data_in),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
`ifdef DIV_CYCLE_COUNT_EN
    .calc_cycles (calc_cycles),
`endif
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: on each rising done, pop the expected result and compare.
  initial begin
    logic done_prev;
    int   busy_cnt;
    exp_t e;
    done_prev = 1'b0;
    busy_cnt  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt  = 0;
        done_prev = 1'b0;
      end else begin
        if (busy) busy_cnt++;
        if (done && !done_prev) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("div_by_zero", div_by_zero, e.dz);
            check("busy_cycles", busy_cnt, e.busy_cycles);
`ifdef DIV_CYCLE_COUNT_EN
            check("calc_cycles", calc_cycles, e.cyc);
`endif
          end
          busy_cnt = 0;
        end
        done_prev = done;
      end
    end
  end

  // Issue start, dividend and divisor; optional start pulses during CALC.
  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b, input bit pulse);
    @(negedge clk); start = 1'b1; data_in = '0;
    @(negedge clk); start = 1'b0; data_in = a;
    @(negedge clk); data_in = b;
    @(negedge clk); data_in = W'($urandom);
    if (pulse) begin
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 70000) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      check("done_timeout", 0, 1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                    input bit pulse);
    exp_t e;
    e.q  = eq;
    e.r  = er;
    e.dz = edz;
    e.busy_cycles = edz ? 3 : int'(eq) + 3;
    e.cyc = edz ? W'(1) : W'(eq + 1'b1);
    sb.push_back(e);
    load(a, b, pulse);
    wait_done();
  endtask

  initial begin
    #12;
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_by_zero, 0);
    @(negedge clk); rst_n = 1'b1;
    // Idle with start low must not begin an operation.
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);

    op(16'd17, 16'd5, 16'd3, 16'd2, 1'b0, 1'b0);
    op(16'd5, 16'd17, 16'd0, 16'd5, 1'b0, 1'b0);
    op(16'd9, 16'd0, 16'hFFFF, 16'd9, 1'b1, 1'b0);
    op(16'd17, 16'd5, 16'd3, 16'd2, 1'b0, 1'b0);
    op(16'd20, 16'd4, 16'd5, 16'd0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("done_hold", done, 1);
    check("hold_quotient", quotient, 5);
    op(16'd65535, 16'd1, 16'd65535, 16'd0, 1'b0, 1'b0);

    // Abort 100/3 mid-CALC with an asynchronous reset.
    load(16'd100, 16'd3, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dz", div_by_zero, 0);
`ifdef DIV_CYCLE_COUNT_EN
    check("abort_calc_cycles", calc_cycles, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    op(16'd100, 16'd3, 16'd33, 16'd1, 1'b0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
